// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg
//   Shared constants for the micro-sequencer: FSM state encoding, default
//   control-vector geometry, strobe bit positions inside the control word
//   and the microcode LAST flag position.
package micro_sequencer_pkg;

  localparam int SEQ_CTRL_WIDTH = 24;
  localparam int SEQ_STEP_BITS  = 4;

  // Externally visible state code (o_state): 0=HALT, 1=FETCH, 2=EXEC.
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seq_state_e;

  // Bit positions of the active-low strobes inside the control word.
  // Bit 0 of a microcode word is the active-high LAST flag instead.
  localparam int UC_LAST_BIT   = 0;
  localparam int CB_INSTR_NWE  = 1;
  localparam int CB_PC_NEN     = 2;
  localparam int CB_PC_LOADN   = 3;
  localparam int CB_MAR_NWE    = 4;
  localparam int CB_SP_NEN     = 5;
  localparam int CB_RAM_NOE    = 6;
  localparam int CB_RAM_NWE    = 7;
  localparam int CB_IO_NRD     = 8;
  localparam int CB_IO_NWR     = 9;

  localparam logic [SEQ_CTRL_WIDTH-1:0] CTRL_IDLE = '1;
  localparam logic [SEQ_CTRL_WIDTH-1:0] CTRL_FETCH =
    CTRL_IDLE & ~((SEQ_CTRL_WIDTH'(1) << CB_INSTR_NWE) |
                  (SEQ_CTRL_WIDTH'(1) << CB_PC_NEN));

endpackage

// File: rtl/seq_debug_ctrl.sv
// seq_debug_ctrl
//   Debug flag logic for the micro-sequencer. Tracks the single-step flag and
//   the breakpoint-skip flag and folds them with the halt request and the
//   breakpoint comparator into one "halt at this boundary" decision.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in_halt        sequencer is in HALT
//   in_fetch       sequencer is in FETCH
//   retire         current EXEC cycle retires the instruction
//   run, step      debug pulses (only honoured in HALT; run wins)
//   halt_req       level halt request
//   bp_hit         breakpoint comparator hit
//   halt_boundary  halt instead of (or during) the next fetch
module seq_debug_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic in_halt,
  input  logic in_fetch,
  input  logic retire,
  input  logic run,
  input  logic step,
  input  logic halt_req,
  input  logic bp_hit,
  output logic halt_boundary
);

  logic single;
  logic bp_skip;

  // The single flag is only meaningful at the retire boundary. While in FETCH
  // it can only be set because a step pulse just left HALT, so it must not
  // halt that fetch.
  assign halt_boundary = halt_req | (single & ~in_fetch) | (bp_hit & ~bp_skip);

  always_ff @(posedge clk) begin
    if (reset) begin
      single  <= 1'b0;
      bp_skip <= 1'b0;
    end else if (in_halt && run) begin
      single  <= 1'b0;
      bp_skip <= 1'b1;
    end else if (in_halt && step) begin
      single  <= 1'b1;
      bp_skip <= 1'b1;
    end else begin
      if (retire)
        single <= 1'b0;
      // Once the resumed instruction has actually been fetched the
      // breakpoint becomes live again.
      if (in_fetch && !halt_boundary)
        bp_skip <= 1'b0;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Fetch/execute controller for the CPU memory unit. In FETCH it drives a
//   fixed fetch word, in EXEC it forwards the external asynchronous microcode
//   ROM word addressed by {instruction code, step}, in HALT all strobes are
//   inactive. Debug run/step/halt and breakpoint halting are resolved at
//   instruction boundaries by seq_debug_ctrl.
// Optional feature: define SEQ_INSTR_COUNT_EN to build the 32-bit retired
//   instruction counter; otherwise o_instrCount is tied to zero.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_instrCode      current instruction code
//   o_ucodeAddress   {i_instrCode, step} to the microcode ROM
//   i_ucodeData      microcode word (combinational ROM read)
//   o_ctrl           active-low control vector
//   i_breakpointHit  PC matches enabled breakpoint
//   i_run, i_step    debug pulses (resume / single instruction)
//   i_haltReq        halt at next instruction boundary
//   o_halted         high in HALT
//   o_state          0=HALT, 1=FETCH, 2=EXEC
//   o_error          sticky step-counter overflow flag
//   o_instrCount     retired instruction count
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int CTRL_WIDTH   = SEQ_CTRL_WIDTH,
  parameter int STEP_BITS    = SEQ_STEP_BITS,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_instrCode,
  output logic [8+STEP_BITS-1:0]  o_ucodeAddress,
  input  logic [CTRL_WIDTH-1:0]   i_ucodeData,
  output logic [CTRL_WIDTH-1:0]   o_ctrl,
  input  logic                    i_breakpointHit,
  input  logic                    i_run,
  input  logic                    i_step,
  input  logic                    i_haltReq,
  output logic                    o_halted,
  output logic [1:0]              o_state,
  output logic                    o_error,
  output logic [31:0]             o_instrCount
);

  localparam logic [CTRL_WIDTH-1:0] IDLE_WORD  = '1;
  localparam logic [CTRL_WIDTH-1:0] FETCH_WORD =
    IDLE_WORD & ~((CTRL_WIDTH'(1) << CB_INSTR_NWE) |
                  (CTRL_WIDTH'(1) << CB_PC_NEN));
  localparam logic [STEP_BITS-1:0]  STEP_MAX   = '1;

  seq_state_e           state;
  logic [STEP_BITS-1:0] step;
  logic                 error;
  logic                 in_exec;
  logic                 last;
  logic                 overflow;
  logic                 retire;
  logic                 halt_boundary;

  assign in_exec  = (state == ST_EXEC);
  assign last     = in_exec && i_ucodeData[UC_LAST_BIT];
  assign overflow = in_exec && (step == STEP_MAX) && !i_ucodeData[UC_LAST_BIT];
  assign retire   = last || overflow;

  seq_debug_ctrl u_debug (
    .clk           (i_clk),
    .reset         (i_reset),
    .in_halt       (state == ST_HALT),
    .in_fetch      (state == ST_FETCH),
    .retire        (retire),
    .run           (i_run),
    .step          (i_step),
    .halt_req      (i_haltReq),
    .bp_hit        (i_breakpointHit),
    .halt_boundary (halt_boundary)
  );

  // The boundary check is applied both when leaving EXEC (so a halting
  // boundary never shows a fetch word) and in FETCH itself (for entries from
  // reset or HALT).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= START_HALTED ? ST_HALT : ST_FETCH;
      step  <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          if (i_run || i_step)
            state <= ST_FETCH;
        end
        ST_FETCH: begin
          step  <= '0;
          state <= halt_boundary ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          if (retire) begin
            step  <= '0;
            state <= halt_boundary ? ST_HALT : ST_FETCH;
            if (overflow)
              error <= 1'b1;
          end else begin
            step <= step + STEP_BITS'(1);
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    o_ctrl = IDLE_WORD;
    case (state)
      ST_FETCH: o_ctrl = halt_boundary ? IDLE_WORD : FETCH_WORD;
      ST_EXEC:  o_ctrl = i_ucodeData;
      default:  o_ctrl = IDLE_WORD;
    endcase
  end

  assign o_ucodeAddress = {i_instrCode, step};
  assign o_halted       = (state == ST_HALT);
  assign o_state        = state;
  assign o_error        = error;

`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] instr_count;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      instr_count <= '0;
    else if (retire)
      instr_count <= instr_count + 32'd1;
  end

  assign o_instrCount = instr_count;
`else
  assign o_instrCount = '0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
//   Scoreboard bench for micro_sequencer: per-cycle stimulus and expected
//   outputs are queued per scenario, then applied and compared cycle by cycle.
module tb_micro_sequencer;

  localparam logic [23:0] W_IDLE  = 24'hFFFFFF;
  localparam logic [23:0] W_FETCH = 24'hFFFFF9;
`ifdef SEQ_INSTR_COUNT_EN
  localparam bit COUNT_ON = 1'b1;
`else
  localparam bit COUNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_instrCode = 8'h05;
  logic [11:0] o_ucodeAddress;
  logic [23:0] i_ucodeData;
  logic [23:0] o_ctrl;
  logic        i_breakpointHit = 1'b0;
  logic        i_run = 1'b0;
  logic        i_step = 1'b0;
  logic        i_haltReq = 1'b0;
  logic        o_halted;
  logic [1:0]  o_state;
  logic        o_error;
  logic [31:0] o_instrCount;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_cnt = 32'd0;

  typedef struct {
    logic rst, run, stp_in, hreq, bp;
    logic [7:0]  code;
    logic [1:0]  st;
    logic [23:0] ctrl;
    logic [3:0]  stp;
    logic        err, ret;
  } vec_t;

  vec_t sb[$];

  always #5 clk = ~clk;

  micro_sequencer dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_instrCode     (i_instrCode),
    .o_ucodeAddress  (o_ucodeAddress),
    .i_ucodeData     (i_ucodeData),
    .o_ctrl          (o_ctrl),
    .i_breakpointHit (i_breakpointHit),
    .i_run           (i_run),
    .i_step          (i_step),
    .i_haltReq       (i_haltReq),
    .o_halted        (o_halted),
    .o_state         (o_state),
    .o_error         (o_error),
    .o_instrCount    (o_instrCount)
  );

  // Step index carrying LAST for each test opcode; -1 means never.
  function automatic int last_of(input logic [7:0] c);
    case (c)
      8'h05:   return 2;
      8'h03:   return 2;
      8'h04:   return 3;
      8'h0F:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [23:0] uword(input logic [7:0] c, input logic [3:0] s);
    int l;
    l = last_of(c);
    return {c, s, 11'h2AB, (l >= 0) && (int'(s) == l)};
  endfunction

  // Microcode ROM model: combinational read.
  always_comb i_ucodeData = uword(o_ucodeAddress[11:4], o_ucodeAddress[3:0]);

  // kind: 0 = idle word, 1 = fetch word, 2 = microcode word for (code, s)
  task automatic push(input logic rst, run, stp_in, hreq, bp, input logic [7:0] code,
                      input logic [1:0] st, input int kind, input int s,
                      input logic err, ret);
    vec_t v;
    v.rst = rst; v.run = run; v.stp_in = stp_in; v.hreq = hreq; v.bp = bp;
    v.code = code; v.st = st; v.stp = 4'(s); v.err = err; v.ret = ret;
    v.ctrl = (kind == 0) ? W_IDLE : (kind == 1) ? W_FETCH : uword(code, 4'(s));
    sb.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    i_reset = v.rst; i_run = v.run; i_step = v.stp_in;
    i_haltReq = v.hreq; i_breakpointHit = v.bp; i_instrCode = v.code;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (o_state !== 2'd1) begin miscompares++; $display("FAIL reset_state got=%0d exp=1", o_state); end
    vectors++;
    if (o_ctrl !== W_FETCH) begin miscompares++; $display("FAIL reset_ctrl got=%h exp=%h", o_ctrl, W_FETCH); end
    vectors++;
    if (o_error !== 1'b0) begin miscompares++; $display("FAIL reset_error got=%b exp=0", o_error); end
    vectors++;
    if (o_instrCount !== 32'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", o_instrCount); end
  endtask

  task automatic test_fetch_exec;
    vec_t v; logic [71:0] got, exp; int cyc = 0;
    push(0,0,0,0,0, 8'h05, 1, 1, 0, 0, 0);
    for (int s = 0; s < 3; s++) push(0,0,0,0,0, 8'h05, 2, 2, s, 0, s == 2);
    push(0,0,0,1,0, 8'h05, 1, 0, 0, 0, 0);   // halt request in FETCH: no strobes
    push(0,0,0,0,0, 8'h05, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk); apply(v); #1;
      got = {o_state, o_ctrl, o_ucodeAddress, o_error, o_halted, o_instrCount};
      exp = {v.st, v.ctrl, v.code, v.stp, v.err, v.st == 2'd0, COUNT_ON ? exp_cnt : 32'd0};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL fetch_exec cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (v.ret) exp_cnt++;
      cyc++;
    end
  endtask

  task automatic test_breakpoint;
    vec_t v; logic [71:0] got, exp; int cyc = 0;
    push(0,1,0,0,1, 8'h05, 0, 0, 0, 0, 0);   // resume with hit still high
    push(0,0,0,0,1, 8'h05, 1, 1, 0, 0, 0);
    for (int s = 0; s < 3; s++) push(0,0,0,0,1, 8'h05, 2, 2, s, 0, s == 2);
    push(0,0,0,0,1, 8'h05, 0, 0, 0, 0, 0);   // halted again at boundary
    push(0,0,0,0,1, 8'h05, 0, 0, 0, 0, 0);
    push(0,1,0,0,1, 8'h05, 0, 0, 0, 0, 0);
    push(0,0,0,0,0, 8'h05, 1, 1, 0, 0, 0);
    push(0,1,0,0,0, 8'h05, 2, 2, 0, 0, 0);   // run pulse outside HALT ignored
    push(0,0,1,0,0, 8'h05, 2, 2, 1, 0, 0);   // step pulse outside HALT ignored
    push(0,0,0,0,0, 8'h05, 2, 2, 2, 0, 1);
    push(0,0,0,0,1, 8'h05, 1, 0, 0, 0, 0);   // hit seen in FETCH: no strobes
    push(0,0,0,0,0, 8'h05, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk); apply(v); #1;
      got = {o_state, o_ctrl, o_ucodeAddress, o_error, o_halted, o_instrCount};
      exp = {v.st, v.ctrl, v.code, v.stp, v.err, v.st == 2'd0, COUNT_ON ? exp_cnt : 32'd0};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL breakpoint cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (v.ret) exp_cnt++;
      cyc++;
    end
  endtask

  task automatic test_single_step;
    vec_t v; logic [71:0] got, exp; int cyc = 0;
    push(0,0,1,0,0, 8'h03, 0, 0, 0, 0, 0);
    push(0,0,0,0,0, 8'h03, 1, 1, 0, 0, 0);
    for (int s = 0; s < 3; s++) push(0,0,0,0,0, 8'h03, 2, 2, s, 0, s == 2);
    push(0,0,0,0,0, 8'h03, 0, 0, 0, 0, 0);
    push(0,0,0,0,0, 8'h03, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk); apply(v); #1;
      got = {o_state, o_ctrl, o_ucodeAddress, o_error, o_halted, o_instrCount};
      exp = {v.st, v.ctrl, v.code, v.stp, v.err, v.st == 2'd0, COUNT_ON ? exp_cnt : 32'd0};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL single_step cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (v.ret) exp_cnt++;
      cyc++;
    end
  endtask

  task automatic test_halt_req;
    vec_t v; logic [71:0] got, exp; int cyc = 0;
    push(0,1,0,0,0, 8'h04, 0, 0, 0, 0, 0);
    push(0,0,0,0,0, 8'h04, 1, 1, 0, 0, 0);
    push(0,0,0,0,0, 8'h04, 2, 2, 0, 0, 0);
    for (int s = 1; s < 4; s++) push(0,0,0,1,0, 8'h04, 2, 2, s, 0, s == 3);
    push(0,0,0,1,0, 8'h04, 0, 0, 0, 0, 0);
    push(0,0,0,0,0, 8'h04, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk); apply(v); #1;
      got = {o_state, o_ctrl, o_ucodeAddress, o_error, o_halted, o_instrCount};
      exp = {v.st, v.ctrl, v.code, v.stp, v.err, v.st == 2'd0, COUNT_ON ? exp_cnt : 32'd0};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL halt_req cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (v.ret) exp_cnt++;
      cyc++;
    end
  endtask

  task automatic test_overflow;
    vec_t v; logic [71:0] got, exp; int cyc = 0;
    push(0,1,0,0,0, 8'h0F, 0, 0, 0, 0, 0);
    push(0,0,0,0,0, 8'h0F, 1, 1, 0, 0, 0);
    for (int s = 0; s < 16; s++) push(0,0,0,0,0, 8'h0F, 2, 2, s, 0, s == 15);
    push(0,0,0,1,0, 8'h0F, 1, 0, 0, 1, 0);   // forced FETCH, error now set
    push(0,0,0,0,0, 8'h0F, 0, 0, 0, 1, 0);
    push(0,0,0,0,0, 8'h0F, 0, 0, 0, 1, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk); apply(v); #1;
      got = {o_state, o_ctrl, o_ucodeAddress, o_error, o_halted, o_instrCount};
      exp = {v.st, v.ctrl, v.code, v.stp, v.err, v.st == 2'd0, COUNT_ON ? exp_cnt : 32'd0};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL overflow cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (v.ret) exp_cnt++;
      cyc++;
    end
  endtask

  task automatic test_back_to_back;
    vec_t v; logic [71:0] got, exp; int cyc = 0;
    push(0,1,1,0,0, 8'h05, 0, 0, 0, 1, 0);   // run and step together: run wins
    push(0,0,0,0,0, 8'h05, 1, 1, 0, 1, 0);
    for (int s = 0; s < 3; s++) push(0,0,0,0,0, 8'h05, 2, 2, s, 1, s == 2);
    push(0,0,0,0,0, 8'h03, 1, 1, 0, 1, 0);
    for (int s = 0; s < 3; s++) push(0,0,0,0,0, 8'h03, 2, 2, s, 1, s == 2);
    push(0,0,0,1,0, 8'h03, 1, 0, 0, 1, 0);
    push(0,0,0,0,0, 8'h03, 0, 0, 0, 1, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk); apply(v); #1;
      got = {o_state, o_ctrl, o_ucodeAddress, o_error, o_halted, o_instrCount};
      exp = {v.st, v.ctrl, v.code, v.stp, v.err, v.st == 2'd0, COUNT_ON ? exp_cnt : 32'd0};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (v.ret) exp_cnt++;
      cyc++;
    end
  endtask

  task automatic test_reset_mid;
    vec_t v; logic [71:0] got, exp; int cyc = 0;
    push(0,1,0,0,0, 8'h04, 0, 0, 0, 1, 0);
    push(0,0,0,0,0, 8'h04, 1, 1, 0, 1, 0);
    push(0,0,0,0,0, 8'h04, 2, 2, 0, 1, 0);
    push(0,0,0,0,0, 8'h04, 2, 2, 1, 1, 0);
    push(1,0,0,0,0, 8'h04, 2, 2, 2, 1, 0);   // reset sampled at end of step 2
    push(0,0,0,0,0, 8'h04, 1, 1, 0, 0, 0);
    push(0,0,0,0,0, 8'h04, 2, 2, 0, 0, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk); apply(v); #1;
      got = {o_state, o_ctrl, o_ucodeAddress, o_error, o_halted, o_instrCount};
      exp = {v.st, v.ctrl, v.code, v.stp, v.err, v.st == 2'd0, COUNT_ON ? exp_cnt : 32'd0};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL reset_mid cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (v.ret) exp_cnt++;
      if (v.rst) exp_cnt = 32'd0;
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch_exec();
    test_breakpoint();
    test_single_step();
    test_halt_req();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
